mmss_seconds_counter: RTL and testbench
=======================================

// Module: mmss_seconds_counter
// PURPOSE
//  Consumer of the 1 Hz single-cycle enable pulse produced by the clock divider.
//  Counts elapsed time as MM:SS in four BCD digits, from 00:00 to 59:59.
//  Supports run/pause, synchronous clear and a selectable wrap/saturate policy.
//  The BCD digits feed the Basys 3 seven-segment display path downstream.
// PARAMETERS
//  WRAP_AT_MAX  1  1: 59:59 -> 00:00 on next tick; 0: hold at 59:59
//  TICK_DIV     1  ticks per count step (1..255); 1 = count every enable pulse
// PORTS
//  clk_in          in   1  100 MHz system clock; all logic on posedge
//  reset_in        in   1  synchronous, active-high reset
//  enable_in       in   1  tick strobe; each high cycle is one tick
//  run_in          in   1  level; 1 = ticks accepted, 0 = paused (ticks ignored)
//  clear_in        in   1  synchronous clear to 00:00, pauses nothing
//  sec_ones_out    out  4  BCD 0..9
//  sec_tens_out    out  4  BCD 0..5
//  min_ones_out    out  4  BCD 0..9
//  min_tens_out    out  4  BCD 0..5
//  rollover_out    out  1  1-cycle pulse on 59:59 -> 00:00 (WRAP_AT_MAX=1 only)
//  at_max_out      out  1  level; high while display reads 59:59
// BEHAVIOUR
//  - Reset: all digits 0, prescale count 0, rollover_out 0, at_max_out 0.
//  - Priority per edge: reset_in > clear_in > accepted tick.
//  - Accepted tick = enable_in & run_in. Prescaler counts accepted ticks
//    0..TICK_DIV-1; a count step occurs on the tick reaching TICK_DIV-1, then
//    prescaler returns to 0. TICK_DIV=1: every accepted tick is a step.
//  - Latency: step on edge N -> new digits visible after edge N (registered,
//    1 cycle); no combinational path from inputs to outputs.
//  - Step: sec_ones+1; at 9 -> 0 and carry to sec_tens; sec_tens at 5 -> 0,
//    carry to min_ones; min_ones at 9 -> 0, carry to min_tens; min_tens at 5 ->
//    end of range.
//  - End of range (step while 59:59): WRAP_AT_MAX=1 -> all digits 0 and
//    rollover_out=1 for exactly that one cycle; WRAP_AT_MAX=0 -> digits hold,
//    rollover_out stays 0, prescaler keeps running.
//  - at_max_out registered alongside digits; asserts the cycle 59:59 appears.
//  - clear_in: digits and prescaler -> 0 next edge; coincident tick dropped;
//    rollover_out 0. Clear while run_in=1 resumes counting on following ticks.
//  - run_in=0: digits and prescaler frozen; enable_in ignored.
//  - enable_in held high k cycles = k ticks (no edge detection here).
//  - Digits never leave legal BCD range; illegal states unreachable.
// STRUCTURE
//  - Shared pkg/header: BCD width (4), SEC_TENS_MAX=5, MIN_TENS_MAX=5, DIGIT_MAX=9.
//  - Sub-module bcd_digit: params MAX; inputs clk_in, reset_in, clr, inc;
//    outputs digit[3:0], carry (comb: inc & digit==MAX). Instantiated 4x,
//    carry chained; top holds prescaler, wrap/saturate gating, flags.
// TESTING
//  1 reset_in high 2 cycles, enable_in=1 -> all digits 0, flags 0.
//  2 run=1, 10 single-cycle ticks -> 00:10 (sec_tens=1, sec_ones=0) one cycle
//    after 10th tick.
//  3 preload via 3599 ticks -> 59:59, at_max_out=1; one more tick, WRAP=1 ->
//    00:00, rollover_out high exactly 1 cycle.
//  4 WRAP_AT_MAX=0, at 59:59 apply 5 ticks -> stays 59:59, rollover_out never 1.
//  5 at 00:42, run_in=0 and 3 ticks -> still 00:42; clear_in with coincident
//    tick -> 00:00, next tick -> 00:01.
//  6 TICK_DIV=4, 9 ticks -> 00:02; clear after 2 ticks restarts prescaler
//    (4 more ticks needed for 00:01).

Source files
------------

// File: rtl/mmss_seconds_counter_pkg.sv
// Shared constants and types for the MM:SS elapsed-time counter.
// Every digit is a 4-bit BCD value; the tens digits stop at 5.
package mmss_seconds_counter_pkg;

    localparam int BCD_W   = 4;
    localparam int PRESC_W = 8;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t DIGIT_MAX    = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_TENS_MAX = 4'd5;

endpackage

// File: rtl/mmss_seconds_counter_bcd_digit.sv
// One BCD digit that counts from 0 to MAX and wraps back to 0.
// The digit raises carry in the same cycle that it wraps, so digits chain directly.
module bcd_digit
    import mmss_seconds_counter_pkg::*;
#(
    parameter bcd_t MAX = DIGIT_MAX
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic clr,
    input  logic inc,
    output bcd_t digit,
    output logic carry
);

    assign carry = inc & (digit == MAX);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= carry ? '0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/mmss_seconds_counter.sv
// MM:SS elapsed-time counter that is driven by a 1 Hz enable strobe.
// Supports a tick prescaler, pause, synchronous clear, and a wrap or saturate policy at 59:59.
module mmss_seconds_counter
    import mmss_seconds_counter_pkg::*;
#(
    parameter int WRAP_AT_MAX = 1,
    parameter int TICK_DIV    = 1
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic enable_in,
    input  logic run_in,
    input  logic clear_in,
    output bcd_t sec_ones_out,
    output bcd_t sec_tens_out,
    output bcd_t min_ones_out,
    output bcd_t min_tens_out,
    output logic rollover_out,
    output logic at_max_out
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam bcd_t               PRE_MAX    = DIGIT_MAX - 4'd1;

    logic [PRESC_W-1:0] presc;
    logic tick_ok;
    logic step;
    logic step_eff;
    logic at_max_now;
    logic at_pre_max;
    logic sec_ones_carry;
    logic sec_tens_carry;
    logic min_ones_carry;
    logic min_tens_carry;

    assign tick_ok = enable_in & run_in;
    assign step    = tick_ok & (presc == PRESC_LAST);

    assign at_max_now = (sec_ones_out == DIGIT_MAX) && (sec_tens_out == SEC_TENS_MAX) &&
                        (min_ones_out == DIGIT_MAX) && (min_tens_out == MIN_TENS_MAX);
    assign at_pre_max = (sec_ones_out == PRE_MAX)   && (sec_tens_out == SEC_TENS_MAX) &&
                        (min_ones_out == DIGIT_MAX) && (min_tens_out == MIN_TENS_MAX);

    // In saturate mode the digits stop advancing at 59:59, but the prescaler keeps running.
    assign step_eff = step & ((WRAP_AT_MAX != 0) | ~at_max_now);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            presc <= '0;
        end else if (clear_in) begin
            presc <= '0;
        end else if (tick_ok) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end
    end

    bcd_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clr      (clear_in),
        .inc      (step_eff),
        .digit    (sec_ones_out),
        .carry    (sec_ones_carry)
    );

    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clr      (clear_in),
        .inc      (sec_ones_carry),
        .digit    (sec_tens_out),
        .carry    (sec_tens_carry)
    );

    bcd_digit #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clr      (clear_in),
        .inc      (sec_tens_carry),
        .digit    (min_ones_out),
        .carry    (min_ones_carry)
    );

    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clr      (clear_in),
        .inc      (min_ones_carry),
        .digit    (min_tens_out),
        .carry    (min_tens_carry)
    );

    // Carry out of the top digit can occur only when 59:59 wraps to 00:00.
    // The flags are registered so that they line up with the new digit values.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            rollover_out <= 1'b0;
            at_max_out   <= 1'b0;
        end else begin
            rollover_out <= min_tens_carry & ~clear_in;
            at_max_out   <= ~clear_in & ((at_max_now & ~step_eff) | (at_pre_max & step_eff));
        end
    end

endmodule

// File: tb/tb_mmss_seconds_counter.sv
// Self-checking bench for three counter configurations (wrap/div1, saturate/div1, wrap/div4).
// All three configurations share one stimulus stream, and each one is checked against its own elapsed-seconds model.
module tb_mmss_seconds_counter;

    localparam int NDUT = 3;
    localparam int MODEL_DIV [NDUT]  = '{1, 1, 4};
    localparam int MODEL_WRAP [NDUT] = '{1, 0, 1};

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic reset_in  = 1'b1;
    logic enable_in = 1'b0;
    logic run_in    = 1'b0;
    logic clear_in  = 1'b0;

    logic [3:0] so [NDUT];
    logic [3:0] st [NDUT];
    logic [3:0] mo [NDUT];
    logic [3:0] mt [NDUT];
    logic       roll [NDUT];
    logic       atmax [NDUT];

    int  model_total [NDUT];
    int  model_presc [NDUT];
    bit  model_roll [NDUT];
    int  tests_run    = 0;
    int  tests_failed = 0;
    bit  sat_roll_seen;

    mmss_seconds_counter #(.WRAP_AT_MAX(1), .TICK_DIV(1)) dut_wrap (
        .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in), .run_in(run_in),
        .clear_in(clear_in), .sec_ones_out(so[0]), .sec_tens_out(st[0]),
        .min_ones_out(mo[0]), .min_tens_out(mt[0]), .rollover_out(roll[0]), .at_max_out(atmax[0])
    );

    mmss_seconds_counter #(.WRAP_AT_MAX(0), .TICK_DIV(1)) dut_sat (
        .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in), .run_in(run_in),
        .clear_in(clear_in), .sec_ones_out(so[1]), .sec_tens_out(st[1]),
        .min_ones_out(mo[1]), .min_tens_out(mt[1]), .rollover_out(roll[1]), .at_max_out(atmax[1])
    );

    mmss_seconds_counter #(.WRAP_AT_MAX(1), .TICK_DIV(4)) dut_div4 (
        .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in), .run_in(run_in),
        .clear_in(clear_in), .sec_ones_out(so[2]), .sec_tens_out(st[2]),
        .min_ones_out(mo[2]), .min_tens_out(mt[2]), .rollover_out(roll[2]), .at_max_out(atmax[2])
    );

    function automatic logic [15:0] to_bcd(input int t);
        return {4'(t / 600), 4'((t / 60) % 10), 4'((t / 10) % 6), 4'(t % 10)};
    endfunction

    function automatic logic [15:0] digits_of(input int k);
        return {mt[k], mo[k], st[k], so[k]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive the inputs, advance every model on the edge, then check every configuration.
    task automatic applyStimulus(input logic rst, input logic en, input logic run, input logic clr);
        @(negedge clk_in);
        reset_in  = rst;
        enable_in = en;
        run_in    = run;
        clear_in  = clr;
        @(posedge clk_in);
        for (int k = 0; k < NDUT; k++) begin
            model_roll[k] = 1'b0;
            if (rst || clr) begin
                model_total[k] = 0;
                model_presc[k] = 0;
            end else if (en && run) begin
                model_presc[k] = model_presc[k] + 1;
                if (model_presc[k] == MODEL_DIV[k]) begin
                    model_presc[k] = 0;
                    if (model_total[k] < 3599) begin
                        model_total[k] = model_total[k] + 1;
                    end else if (MODEL_WRAP[k] != 0) begin
                        model_total[k] = 0;
                        model_roll[k]  = 1'b1;
                    end
                end
            end
        end
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("dut%0d_digits", k), 32'(digits_of(k)), 32'(to_bcd(model_total[k])));
            checkOutput($sformatf("dut%0d_rollover", k), 32'(roll[k]), 32'(model_roll[k]));
            checkOutput($sformatf("dut%0d_at_max", k), 32'(atmax[k]), 32'(model_total[k] == 3599));
        end
        if (roll[1] === 1'b1) sat_roll_seen = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            model_total[k] = 0;
            model_presc[k] = 0;
            model_roll[k]  = 1'b0;
        end
        sat_roll_seen = 1'b0;

        // Reset is held high for two cycles with the enable active.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("reset_digits", 32'(digits_of(0)), 32'h0000);
        checkOutput("reset_at_max", 32'(atmax[0]), 32'h0);
        checkOutput("reset_rollover", 32'(roll[0]), 32'h0);

        // Ten single-cycle ticks.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("ten_ticks", 32'(digits_of(0)), 32'h0010);
        checkOutput("div4_ten_ticks", 32'(digits_of(2)), 32'h0002);

        // With the divide-by-4 prescaler, nine ticks give two steps. A clear then restarts the prescaler.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("div4_nine_ticks", 32'(digits_of(2)), 32'h0002);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("div4_restart_three", 32'(digits_of(2)), 32'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("div4_restart_four", 32'(digits_of(2)), 32'h0001);

        // Run to 59:59, then test wrap and saturate at the end of the range.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3599; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("wrap_at_5959", 32'(digits_of(0)), 32'h5959);
        checkOutput("wrap_at_max_flag", 32'(atmax[0]), 32'h1);
        checkOutput("sat_at_5959", 32'(digits_of(1)), 32'h5959);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("wrap_to_0000", 32'(digits_of(0)), 32'h0000);
        checkOutput("wrap_rollover_pulse", 32'(roll[0]), 32'h1);
        checkOutput("wrap_at_max_drop", 32'(atmax[0]), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("wrap_rollover_one_cycle", 32'(roll[0]), 32'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("sat_holds_5959", 32'(digits_of(1)), 32'h5959);
        checkOutput("sat_at_max_held", 32'(atmax[1]), 32'h1);
        checkOutput("sat_no_rollover", 32'(sat_roll_seen), 32'h0);

        // Pause at 00:42, then a clear that coincides with a tick.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 42; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("count_0042", 32'(digits_of(0)), 32'h0042);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("paused_0042", 32'(digits_of(0)), 32'h0042);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("clear_drops_tick", 32'(digits_of(0)), 32'h0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("resume_after_clear", 32'(digits_of(0)), 32'h0001);

        // Random traffic against the models.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
